counter_4b_sched: RTL and testbench
===================================

Name: counter_4b_sched

Overview:
- Two-requester scheduler/sequencer for the 4-bit counter datapath (counter_4b / counter_4b_syn).
- Arbitrates round-robin between two clients. Each client submits a job: start value, count mode and run length.
- For the granted job it loads the counter, enables it for exactly the requested number of cycles, then returns final Q and the rco (wrap) count to the owner.
- Sits between client logic and the counter's enable/mode/D inputs. It is the only driver of those inputs.

Parameters:
- LEN_W, 4, width of the per-job run-length field (max run = 2^LEN_W - 1 cycles).
- WRAP_W, 4, width of the saturating wrap counter returned to the client.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  client 0 job request; held high until gnt0.
- req0_mode  in  2  client 0 counter mode.
- req0_D  in  4  client 0 start value.
- req0_len  in  LEN_W  client 0 run length in enabled cycles.
- req1, req1_mode, req1_D, req1_len  in  1/2/4/LEN_W  same fields for client 1.
- gnt0, gnt1  out  1  one-cycle grant pulse; request fields were latched.
- done0, done1  out  1  one-cycle completion pulse to the job owner.
- result_Q  out  4  final counter value; valid while done0/done1 is high.
- wraps  out  WRAP_W  count of rco cycles seen during RUN; valid with done.
- busy  out  1  high in any state other than IDLE.
- cnt_Q  in  4  counter Q.
- cnt_rco  in  1  counter rco.
- cnt_enable  out  1  drives counter enable.
- cnt_mode  out  2  drives counter mode.
- cnt_D  out  4  drives counter D.

Behaviour:
- Counter contract (decided):
  - Modes: 00 = up by 3, 01 = down by 1, 10 = up by 1, 11 = parallel load D.
  - Q updates on the clk edge when enable = 1.
  - rco is high combinationally while Q sits at the terminal count for the current direction (15 counting up, 0 counting down).
- Reset (asynchronous): state = IDLE; rr_ptr favours client 0. All of the following go to 0: gnt*, done*, busy, cnt_enable, cnt_mode, cnt_D, result_Q, wraps, and the internal job registers.
- Reset asserted mid-job aborts the job immediately. No done is issued; the client must re-request.
- FSM (Moore outputs decoded from state/registers):
  - IDLE: cnt_enable = 0. If any req is high, select the winner. Latch mode/D/len, then go to GRANT.
  - Winner selection: a single requester wins. If both request, the requester not served last wins; after reset, client 0 wins.
  - GRANT (1 cycle): gnt_owner = 1; cnt_mode = 11, cnt_D = latched D, cnt_enable = 1, so the counter loads D. wraps is cleared. Next state is RUN if len != 0, else DONE.
  - RUN (len cycles): cnt_enable = 1, cnt_mode = latched mode, cnt_D = latched D. The remaining-length counter decrements each cycle; leave for DONE at remaining == 1. On each edge in RUN with cnt_rco = 1, wraps increments, saturating at 2^WRAP_W - 1.
  - DONE (1 cycle): cnt_enable = 0; done_owner = 1; result_Q = cnt_Q. rr_ptr is updated to favour the other client. Next state is IDLE.
- Latency: a req sampled in IDLE at edge k gives GRANT in cycle k+1, RUN in cycles k+2 through k+1+len, and DONE in cycle k+2+len.
- A new job can be selected in the first IDLE cycle after DONE.
- Request fields are sampled only at selection. Changes after selection are ignored.
- A req that drops before its gnt is simply not served. No error is raised.
- A client's req still high in the cycle after its own done is treated as a new request. Round-robin still gives the other client priority.
- len = 0: GRANT goes straight to DONE; result_Q = D, wraps = 0.
- Latched mode 11 in RUN is legal: the counter reloads D every cycle, so result_Q = D.
- Arithmetic: the counter wraps modulo 16. The scheduler itself does no arithmetic on Q.

Test Plan:
- Reset mid-RUN (client 0, len = 10, reset at RUN cycle 3) -> all outputs 0 immediately; no done0; IDLE after release; next simultaneous request granted to client 0.
- Client 0: mode 10, D = 3, len = 5 -> gnt0 one cycle after req; done0 seven cycles after the req edge; result_Q = 8, wraps = 0.
- Client 1: mode 10, D = 14, len = 4 -> Q in RUN = 14, 15, 0, 1; result_Q = 2; wraps = 1.
- Client 0: mode 01, D = 2, len = 4 -> result_Q = 14, wraps = 1. Then mode 00, D = 0, len = 3 -> result_Q = 9, wraps = 0.
- Both request continuously from reset -> grants alternate 0, 1, 0, 1. done always goes to the matching owner; busy drops for exactly one IDLE cycle between jobs.
- Client 1: len = 0, D = 7 -> GRANT then DONE; result_Q = 7, wraps = 0; cnt_enable high for exactly one cycle (the load).

Source files
------------

// File: rtl/counter_4b_sched.sv
// Round-robin job sequencer for the 4-bit counter: loads a client's start value, runs the
// counter for the requested number of cycles, then returns the final Q and rco count.
module counter_4b_sched #(
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [1:0]        req0_mode,
  input  logic [3:0]        req0_D,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic              req1,
  input  logic [1:0]        req1_mode,
  input  logic [3:0]        req1_D,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [3:0]        result_Q,
  output logic [WRAP_W-1:0] wraps,
  output logic              busy,
  input  logic [3:0]        cnt_Q,
  input  logic              cnt_rco,
  output logic              cnt_enable,
  output logic [1:0]        cnt_mode,
  output logic [3:0]        cnt_D
);

  typedef enum logic [1:0] {StIdle, StGrant, StRun, StDone} state_e;

  localparam logic [1:0]        ModeLoad = 2'b11;
  localparam logic [WRAP_W-1:0] WrapMax  = '1;
  localparam logic [WRAP_W-1:0] WrapOne  = WRAP_W'(1);
  localparam logic [LEN_W-1:0]  LenOne   = LEN_W'(1);

  state_e             state;
  logic               owner;
  logic               rr_ptr;
  logic [1:0]         job_mode;
  logic [3:0]         job_d;
  logic [LEN_W-1:0]   remaining;

  // Winner: a lone requester, or the favoured one (rr_ptr) when both ask.
  logic               pick1;
  logic [1:0]         sel_mode;
  logic [3:0]         sel_d;
  logic [LEN_W-1:0]   sel_len;

  always_comb begin
    pick1 = req1;
    if (req0 && req1) begin
      pick1 = rr_ptr;
    end
    sel_mode = pick1 ? req1_mode : req0_mode;
    sel_d    = pick1 ? req1_D    : req0_D;
    sel_len  = pick1 ? req1_len  : req0_len;
  end

  // Result is only meaningful during the done pulse; the counter has settled by then.
  assign result_Q = (done0 || done1) ? cnt_Q : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      job_mode   <= 2'b00;
      job_d      <= 4'd0;
      remaining  <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      wraps      <= '0;
      busy       <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_mode   <= 2'b00;
      cnt_D      <= 4'd0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            owner      <= pick1;
            job_mode   <= sel_mode;
            job_d      <= sel_d;
            remaining  <= sel_len;
            wraps      <= '0;
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            busy       <= 1'b1;
            cnt_enable <= 1'b1;
            cnt_mode   <= ModeLoad;
            cnt_D      <= sel_d;
            state      <= StGrant;
          end
        end
        StGrant: begin
          if (remaining == '0) begin
            cnt_enable <= 1'b0;
            cnt_mode   <= 2'b00;
            cnt_D      <= 4'd0;
            done0      <= ~owner;
            done1      <= owner;
            state      <= StDone;
          end else begin
            cnt_mode   <= job_mode;
            state      <= StRun;
          end
        end
        StRun: begin
          if (cnt_rco && (wraps != WrapMax)) begin
            wraps <= wraps + WrapOne;
          end
          remaining <= remaining - LenOne;
          if (remaining == LenOne) begin
            cnt_enable <= 1'b0;
            cnt_mode   <= 2'b00;
            cnt_D      <= 4'd0;
            done0      <= ~owner;
            done1      <= owner;
            state      <= StDone;
          end
        end
        StDone: begin
          busy   <= 1'b0;
          rr_ptr <= ~owner;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_4b_sched.sv
// Bench for counter_4b_sched: a behavioural counter plus a job-timeline reference model,
// compared against the DUT every cycle under directed and random traffic.
module tb_counter_4b_sched;

  localparam int LEN_W  = 4;
  localparam int WRAP_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [1:0]        req0_mode = 2'b00, req1_mode = 2'b00;
  logic [3:0]        req0_D = 4'd0, req1_D = 4'd0;
  logic [LEN_W-1:0]  req0_len = '0, req1_len = '0;
  logic              gnt0, gnt1, done0, done1, busy;
  logic [3:0]        result_Q;
  logic [WRAP_W-1:0] wraps;
  logic [3:0]        cnt_Q;
  logic              cnt_rco, cnt_enable;
  logic [1:0]        cnt_mode;
  logic [3:0]        cnt_D;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_4b_sched #(.LEN_W(LEN_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req0_mode(req0_mode), .req0_D(req0_D), .req0_len(req0_len),
    .req1(req1), .req1_mode(req1_mode), .req1_D(req1_D), .req1_len(req1_len),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result_Q(result_Q), .wraps(wraps), .busy(busy),
    .cnt_Q(cnt_Q), .cnt_rco(cnt_rco),
    .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_D(cnt_D)
  );

  // Counter datapath the scheduler drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_Q <= 4'd0;
    else if (cnt_enable) begin
      case (cnt_mode)
        2'b00:   cnt_Q <= cnt_Q + 4'd3;
        2'b01:   cnt_Q <= cnt_Q - 4'd1;
        2'b10:   cnt_Q <= cnt_Q + 4'd1;
        default: cnt_Q <= cnt_D;
      endcase
    end
  end
  assign cnt_rco = (cnt_mode == 2'b01) ? (cnt_Q == 4'd0) : (cnt_Q == 4'd15);

  // Reference model: one job at a time, described by its grant cycle and length.
  int         cyc = 0;
  bit         job_valid = 1'b0;
  int         g_cyc, j_len, j_owner, exp_wr;
  int         last_served = 1;
  logic [1:0] j_mode;
  logic [3:0] j_d, exp_res;

  function automatic void ref_job(input logic [1:0] m, input logic [3:0] d, input int n,
                                  output logic [3:0] res, output int wr);
    int q;
    q  = int'(d);
    wr = 0;
    for (int i = 0; i < n; i++) begin
      if ((m == 2'b01) ? (q == 0) : (q == 15)) wr++;
      case (m)
        2'b00:   q = (q + 3) % 16;
        2'b01:   q = (q + 15) % 16;
        2'b10:   q = (q + 1) % 16;
        default: q = int'(d);
      endcase
    end
    if (wr > 15) wr = 15;
    res = q[3:0];
  endfunction

  function automatic bit model_idle(input int c);
    return !job_valid || (c >= g_cyc + j_len + 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle, update the model with the inputs seen at the edge, compare outputs.
  task automatic cycle();
    int         rel;
    logic [5:0] ev;
    @(negedge clk);
    cyc++;
    if (reset) begin
      job_valid   = 1'b0;
      last_served = 1;
    end else if (model_idle(cyc - 1) && (req0 || req1)) begin
      j_owner = (req0 && req1) ? (1 - last_served) : (req1 ? 1 : 0);
      j_mode  = (j_owner == 1) ? req1_mode : req0_mode;
      j_d     = (j_owner == 1) ? req1_D : req0_D;
      j_len   = (j_owner == 1) ? int'(req1_len) : int'(req0_len);
      ref_job(j_mode, j_d, j_len, exp_res, exp_wr);
      g_cyc       = cyc;
      job_valid   = 1'b1;
      last_served = j_owner;
    end
    ev  = '0;
    rel = 0;
    if (job_valid) begin
      rel   = cyc - g_cyc;
      ev[5] = (rel == 0) && (j_owner == 0);
      ev[4] = (rel == 0) && (j_owner == 1);
      ev[3] = (rel == j_len + 1) && (j_owner == 0);
      ev[2] = (rel == j_len + 1) && (j_owner == 1);
      ev[1] = (rel <= j_len + 1);
      ev[0] = (rel <= j_len);
    end
    check("ctrl{gnt0,gnt1,done0,done1,busy,en}", {gnt0, gnt1, done0, done1, busy, cnt_enable}, ev);
    if (ev[0]) check("cnt_mode_D", {cnt_mode, cnt_D}, {(rel == 0) ? 2'b11 : j_mode, j_d});
    if (ev[3] || ev[2]) begin
      check("result_Q", result_Q, exp_res);
      check("wraps", wraps, exp_wr);
    end
  endtask

  // Directed single-client job with literal expectations.
  task automatic run_job(input int cl, input logic [1:0] m, input logic [3:0] d,
                         input logic [3:0] n, input logic [3:0] e_res, input logic [3:0] e_wr,
                         input int e_lat, input int e_en);
    int gc;
    int ens;
    bit fin;
    gc  = -1;
    ens = 0;
    fin = 1'b0;
    if (cl == 0) begin
      req0 = 1'b1; req0_mode = m; req0_D = d; req0_len = n;
    end else begin
      req1 = 1'b1; req1_mode = m; req1_D = d; req1_len = n;
    end
    for (int i = 0; i < 40 && !fin; i++) begin
      cycle();
      if (cnt_enable) ens++;
      if (gc < 0 && ((cl == 0) ? gnt0 : gnt1)) begin
        gc = cyc;
        check("gnt_latency", i + 1, 1);
        req0 = 1'b0; req1 = 1'b0;
        req0_D = 4'($urandom); req1_D = 4'($urandom);
        req0_len = LEN_W'($urandom); req1_len = LEN_W'($urandom);
      end
      if ((cl == 0) ? done0 : done1) begin
        fin = 1'b1;
        check("done_latency", cyc - gc, e_lat);
        check("job_result_Q", result_Q, e_res);
        check("job_wraps", wraps, e_wr);
        check("enable_cycles", ens, e_en);
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: client %0d got no done, required one within 40 cycles", cl);
    end
    cycle();
  endtask

  int owners[4];
  int ng;

  initial begin
    #1 reset = 1'b1;
    #1 check("reset_state", {gnt0, gnt1, done0, done1, busy, cnt_enable, cnt_mode, cnt_D,
                             result_Q, wraps}, 0);
    cycle();
    reset = 1'b0;
    cycle();

    // Abort mid-RUN: wraps and drive outputs must clear at once, no done.
    req0 = 1'b1; req0_mode = 2'b10; req0_D = 4'd14; req0_len = 4'd10;
    for (int i = 0; i < 5 && !gnt0; i++) cycle();
    check("abort_gnt0_seen", gnt0, 1);
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    #1 check("abort_outputs", {gnt0, gnt1, done0, done1, busy, cnt_enable, cnt_mode, cnt_D,
                               result_Q, wraps}, 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Both clients request continuously: grants alternate starting with client 0.
    req0 = 1'b1; req0_mode = 2'b10; req0_D = 4'd1; req0_len = 4'd2;
    req1 = 1'b1; req1_mode = 2'b01; req1_D = 4'd5; req1_len = 4'd2;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      cycle();
      if (gnt0) begin owners[ng] = 0; ng++; end
      else if (gnt1) begin owners[ng] = 1; ng++; end
    end
    check("alt_grant_count", ng, 4);
    for (int k = 0; k < ng; k++) check("alt_grant_owner", owners[k], k % 2);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    run_job(0, 2'b10, 4'd3,  4'd5, 4'd8,  4'd0, 6, 6);
    run_job(1, 2'b10, 4'd14, 4'd4, 4'd2,  4'd1, 5, 5);
    run_job(0, 2'b01, 4'd2,  4'd4, 4'd14, 4'd1, 5, 5);
    run_job(0, 2'b00, 4'd0,  4'd3, 4'd9,  4'd0, 4, 4);
    run_job(1, 2'b10, 4'd7,  4'd0, 4'd7,  4'd0, 1, 1);
    run_job(1, 2'b11, 4'd15, 4'd3, 4'd15, 4'd3, 4, 4);

    // Random traffic, including dropped requests, field churn and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      reset     = ($urandom_range(0, 399) == 0);
      req0      = ($urandom_range(0, 99) < 55);
      req1      = ($urandom_range(0, 99) < 55);
      req0_mode = 2'($urandom);
      req1_mode = 2'($urandom);
      req0_D    = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom);
      req1_D    = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom);
      req0_len  = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 4));
      req1_len  = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 4));
    end
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    for (int i = 0; i < 25; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
